// File: rtl/bcd_hex_counter.sv
// Up/down counter that counts in binary or per-digit BCD, wraps or saturates at the bounds,
// and drives one active-low 7-segment glyph per digit with optional leading-zero blanking.
module bcd_hex_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  Clkin,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  up,
  input  logic                  bcd,
  input  logic                  sat,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   segs
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] bcd_max, inc_bcd, dec_bcd, load_san;
  logic         at_max, at_min;

  always_comb begin
    bcd_max = '0;
    for (int i = 0; i < int'(DIGITS); i++) bcd_max[4*i +: 4] = 4'd9;
  end

  // Ripple carry/borrow across digits; digits above 9 are left-overs from binary mode.
  always_comb begin
    logic       c;
    logic       b;
    logic [3:0] d;
    inc_bcd  = q_q;
    dec_bcd  = q_q;
    load_san = load_val;
    c        = 1'b1;
    b        = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = q_q[4*i +: 4];
      if (c) begin
        if (d >= 4'd9) begin
          inc_bcd[4*i +: 4] = 4'd0;
        end else begin
          inc_bcd[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
      if (b) begin
        if (d == 4'd0) begin
          dec_bcd[4*i +: 4] = 4'd9;
        end else if (d > 4'd9) begin
          dec_bcd[4*i +: 4] = 4'd9;
          b = 1'b0;
        end else begin
          dec_bcd[4*i +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end
      if (load_val[4*i +: 4] > 4'd9) load_san[4*i +: 4] = 4'd0;
    end
  end

  assign at_max = bcd ? (q_q == bcd_max) : (&q_q);
  assign at_min = (q_q == '0);

  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (load) begin
      q_d = bcd ? load_san : load_val;
    end else if (en) begin
      if (up ? at_max : at_min) begin
        ovf_d = 1'b1;
        if (!sat) q_d = up ? '0 : (bcd ? bcd_max : '1);
      end else if (bcd) begin
        q_d = up ? inc_bcd : dec_bcd;
      end else begin
        q_d = up ? (q_q + W'(1)) : (q_q - W'(1));
      end
    end
  end

  always_ff @(posedge Clkin or posedge clear) begin
    if (clear) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign ovf = ovf_q;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Blank from the top down while digits are zero; digit 0 always shows.
  always_comb begin
    logic lz;
    lz   = blank_lz;
    segs = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lz = lz && (q_q[4*i +: 4] == 4'd0) && (i != 0);
      segs[7*i +: 7] = lz ? 7'h7F : glyph(q_q[4*i +: 4]);
    end
  end

endmodule

// File: doc/bcd_hex_counter.md
# bcd_hex_counter

Parametrised successor to the 16-bit up-counter with hex display. A DIGITS-nibble counter with up/down direction, binary or BCD counting, wrap or saturate at the bounds, synchronous parallel load, a registered overflow flag and per-digit 7-segment decode with optional leading-zero blanking. It sits between the board switches/keys and the HEX displays, and is the general counting block for later labs.

## Interface

- DIGITS, 4: number of 4-bit digits. Counter width W = 4*DIGITS. Legal range 1..8.
- Clkin  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- en  in  1  count enable; one step per clock while high
- up  in  1  direction: 1 = increment, 0 = decrement
- bcd  in  1  count mode: 1 = decimal per digit, 0 = binary
- sat  in  1  bound mode: 1 = saturate, 0 = wrap
- load  in  1  synchronous parallel load
- load_val  in  W  value to load
- blank_lz  in  1  1 = blank leading-zero digits on the display
- Q  out  W  counter value; digit i is Q[4i+3:4i]
- ovf  out  1  registered bound-hit flag
- segs  out  7*DIGITS  digit i on segs[7i+6:7i]; active-low; bit0 = a … bit6 = g

## Operation

- Reset (clear=1, asynchronous): Q=0, ovf=0. Reset overrides everything, including in mid-count, mid-load and at a bound.
- Priority on each edge: clear > load > en. When none is active, Q holds and ovf clears to 0.
- Load:
  - Q <= load_val and ovf <= 0, regardless of en.
  - In BCD mode, any loaded nibble above 9 is stored as 0.
- Bounds:
  - MAX = 2^W-1 in binary mode.
  - MAX = all digits 9 (10^DIGITS-1) in BCD mode.
  - MIN = 0 in both modes.
- Binary step: Q ± 1 modulo 2^W.
- BCD step, up:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - A digit above 9 (left over from a switch out of binary mode) also becomes 0 and carries.
- BCD step, down:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - A digit above 9 becomes 9 and does not borrow.
- Bound hit (en=1, load=0, and either up=1 with Q==MAX or up=0 with Q==MIN):
  - sat=0: Q wraps to MIN (up) or MAX (down).
  - sat=1: Q holds.
  - In both cases ovf <= 1.
- Any other enabled step sets ovf <= 0. With sat=1 and en held at a bound, ovf stays high every cycle.
- The up, bcd and sat inputs may change on any cycle. They take effect at the next edge; no pipeline state is carried.
- Display:
  - Each digit is decoded combinationally from Q: glyphs 0-9 and A-F. Codes A-F appear only in binary mode or for illegal BCD digits.
  - With blank_lz=1, every digit above the most significant nonzero digit drives all-ones (blank).
  - Digit 0 is never blanked.

## Timing

- Q and ovf are registered on the Clkin rising edge: one-cycle latency from en/load to the new value.
- ovf is valid in the same cycle as the Q it describes.
- segs is combinational from Q and blank_lz. There are no extra register stages.
- The clear deassertion edge needs no synchronisation inside the block. The first count occurs on the first rising edge with clear=0.
- Glyph codes (active-low, g..a): 0=1000000, 1=1111001, 9=0010000, A=0001000, F=0001110.

## Test plan

- Reset/hold:
  - Assert clear mid-count with Q=0x1234 -> Q=0 and ovf=0 immediately, without waiting for a clock edge.
  - With en=0 for 5 cycles -> Q stays 0.
- Binary wrap and saturate:
  - load 0xFFFE, then up, sat=0, en for 3 cycles -> Q = 0xFFFF, 0x0000, 0x0001; ovf high only in the cycle Q=0x0000.
  - Repeat with sat=1 -> Q sticks at 0xFFFF and ovf stays high from the second edge onward.
- BCD carry/borrow:
  - load 0x0999, up, bcd=1 -> next Q=0x1000.
  - Then down -> Q=0x0999.
  - load 0x0000 with down, wrap -> Q=0x9999 and ovf=1.
- BCD load sanitise and mode switch:
  - load 0x12AB with bcd=1 -> Q=0x1200.
  - With bcd=0, load 0x00A9, then switch to bcd=1 and count up -> Q=0x0100.
- Priority:
  - load=1 and en=1 on the same edge with load_val=0x0042 -> Q=0x0042 (no increment) and ovf=0.
- Display:
  - Q=0x0070, blank_lz=1 -> digits 3 and 2 all-ones, digit1 = 7 glyph, digit0 = 0 glyph.
  - With blank_lz=0 -> all four digits show glyphs (0,0,7,0).
  - Q=0 with blank_lz=1 -> only digit 0 lit, showing the 0 glyph.
